// File: rtl/fixed_point_alu_seq.sv
// Sequential unsigned Q4.4 ALU: add/sub in one cycle, shift-add multiply and
// restoring divide, with a start/busy/done handshake and a saturated registered result.
module fixed_point_alu_seq #(
    parameter int W_INT  = 4,
    parameter int W_FRAC = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [1:0]                op,
    input  logic [W_INT+W_FRAC-1:0]   a,
    input  logic [W_INT+W_FRAC-1:0]   b,
    output logic                      busy,
    output logic                      done,
    output logic [W_INT-1:0]          int_out,
    output logic [W_FRAC-1:0]         frac_out,
    output logic                      ovf,
    output logic                      dbz
);

    // state  | meaning
    // IDLE   | wait for start
    // ADDSUB | single compute cycle (add, sub, divide by zero)
    // MUL    | shift-add iterations, one multiplier bit per cycle
    // DIV    | restoring iterations, one quotient bit per cycle
    // FIN    | write result, pulse done, return to IDLE

    localparam int W  = W_INT + W_FRAC;
    localparam int WD = W + W_FRAC;
    localparam int WP = 2 * W;
    localparam int WC = $clog2(WD);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        ADDSUB,
        MUL,
        DIV,
        FIN
    } state_t;

    state_t          state;
    logic [1:0]      op_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [WP-1:0]   acc;
    logic [WP-1:0]   mcand;
    logic [W-1:0]    mplier;
    logic [W-1:0]    rem;
    logic [WD-1:0]   quo;
    logic [WC-1:0]   cnt;
    logic [W-1:0]    res_q;
    logic            ovf_q;
    logic            dbz_q;

    logic [W:0]      sum;
    logic [WP-1:0]   acc_nxt;
    logic [WP-1:0]   prod_sh;
    logic [W:0]      rem_sh;
    logic            rem_ge;
    logic [W-1:0]    rem_nxt;
    logic [WD-1:0]   quo_nxt;

    always_comb begin
        sum     = {1'b0, a_q} + {1'b0, b_q};
        acc_nxt = mplier[0] ? (acc + mcand) : acc;
        prod_sh = acc_nxt >> W_FRAC;
        rem_sh  = {rem, quo[WD-1]};
        rem_ge  = (rem_sh >= {1'b0, b_q});
        rem_nxt = rem_ge ? W'(rem_sh - {1'b0, b_q}) : rem_sh[W-1:0];
        quo_nxt = {quo[WD-2:0], rem_ge};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            rem      <= '0;
            quo      <= '0;
            cnt      <= '0;
            res_q    <= '0;
            ovf_q    <= 1'b0;
            dbz_q    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            int_out  <= '0;
            frac_out <= '0;
            ovf      <= 1'b0;
            dbz      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q   <= op;
                        a_q    <= a;
                        b_q    <= b;
                        acc    <= '0;
                        mcand  <= {{W{1'b0}}, a};
                        mplier <= b;
                        rem    <= '0;
                        quo    <= {a, {W_FRAC{1'b0}}};
                        busy   <= 1'b1;
                        case (op)
                            OP_MUL: begin
                                cnt   <= WC'(W - 1);
                                state <= MUL;
                            end
                            OP_DIV: begin
                                cnt   <= WC'(WD - 1);
                                // divide by zero spends one compute cycle so it retires like add/sub
                                state <= (b == '0) ? ADDSUB : DIV;
                            end
                            default: state <= ADDSUB;
                        endcase
                    end
                end
                ADDSUB: begin
                    dbz_q <= 1'b0;
                    case (op_q)
                        OP_ADD: begin
                            res_q <= sum[W] ? '1 : sum[W-1:0];
                            ovf_q <= sum[W];
                        end
                        OP_SUB: begin
                            res_q <= (a_q < b_q) ? '0 : (a_q - b_q);
                            ovf_q <= (a_q < b_q);
                        end
                        OP_DIV: begin
                            res_q <= '1;
                            ovf_q <= 1'b0;
                            dbz_q <= 1'b1;
                        end
                        default: begin
                            res_q <= '0;
                            ovf_q <= 1'b0;
                        end
                    endcase
                    state <= FIN;
                end
                MUL: begin
                    acc    <= acc_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    if (cnt == '0) begin
                        ovf_q <= (prod_sh[WP-1:W] != '0);
                        res_q <= (prod_sh[WP-1:W] != '0) ? '1 : prod_sh[W-1:0];
                        dbz_q <= 1'b0;
                        state <= FIN;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DIV: begin
                    rem <= rem_nxt;
                    quo <= quo_nxt;
                    if (cnt == '0) begin
                        ovf_q <= (quo_nxt[WD-1:W] != '0);
                        res_q <= (quo_nxt[WD-1:W] != '0) ? '1 : quo_nxt[W-1:0];
                        dbz_q <= 1'b0;
                        state <= FIN;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                FIN: begin
                    {int_out, frac_out} <= res_q;
                    ovf   <= ovf_q;
                    dbz   <= dbz_q;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fixed_point_alu_seq.sv
// Scoreboard bench for fixed_point_alu_seq: directed vectors push expected
// result/flags/done-cycle, a monitor pops and compares on every done pulse.
module tb_fixed_point_alu_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [1:0] op = 2'b00;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       busy, done, ovf, dbz;
    logic [3:0] int_out, frac_out;

    fixed_point_alu_seq #(.W_INT(4), .W_FRAC(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .int_out(int_out), .frac_out(frac_out),
        .ovf(ovf), .dbz(dbz)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] res;
        logic       ovf;
        logic       dbz;
        int         when;
    } exp_t;

    exp_t sb[$];
    exp_t e_mon;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 expected none (cycle %0d)", cyc);
            end else begin
                e_mon = sb.pop_front();
                chk("result", {int_out, frac_out}, e_mon.res);
                chk("ovf", ovf, e_mon.ovf);
                chk("dbz", dbz, e_mon.dbz);
                chk("done_cycle", cyc, e_mon.when);
                chk("busy_at_done", busy, 0);
            end
        end
    end

    task automatic push(input logic [7:0] r, input logic ov, input logic dz, input int when);
        exp_t e;
        e.res = r; e.ovf = ov; e.dbz = dz; e.when = when;
        sb.push_back(e);
    endtask

    // Drives one request; returns N (the accept edge) after the accept edge.
    task automatic issue(input logic [1:0] o, input logic [7:0] aa, input logic [7:0] bb,
                         input int lat, input logic [7:0] r, input logic ov, input logic dz,
                         input bit expect_done, output int n);
        @(negedge clk);
        start = 1'b1; op = o; a = aa; b = bb;
        @(posedge clk);
        #1;
        n = cyc;
        start = 1'b0;
        a = ~aa; b = ~bb;
        if (expect_done) push(r, ov, dz, n + lat);
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && sb.size() != 0; k++) begin
            @(posedge clk);
            #2;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", {int_out, frac_out}, 0);
        chk("rst_flags", {ovf, dbz}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // add 0x1A + 0x24 = 0x3E
        issue(2'b00, 8'h1A, 8'h24, 2, 8'h3E, 1'b0, 1'b0, 1'b1, n);
        drain();

        // mul 0x1A * 0x24 = 936 -> 0x3A; busy held N..N+8, start pulse ignored
        issue(2'b10, 8'h1A, 8'h24, 9, 8'h3A, 1'b0, 1'b0, 1'b1, n);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            chk("mul_busy", busy, 1);
            start = (k == 3 || k == 6);
            op = 2'b00; a = 8'h01; b = 8'h01;
        end
        @(negedge clk);
        start = 1'b0;
        drain();

        issue(2'b11, 8'h30, 8'h20, 13, 8'h18, 1'b0, 1'b0, 1'b1, n);
        drain();
        issue(2'b11, 8'hF0, 8'h01, 13, 8'hFF, 1'b1, 1'b0, 1'b1, n);
        drain();
        issue(2'b10, 8'hF0, 8'h20, 9, 8'hFF, 1'b1, 1'b0, 1'b1, n);
        drain();
        issue(2'b01, 8'h10, 8'h20, 2, 8'h00, 1'b1, 1'b0, 1'b1, n);
        drain();
        issue(2'b01, 8'h55, 8'h23, 2, 8'h32, 1'b0, 1'b0, 1'b1, n);
        drain();
        issue(2'b00, 8'hF0, 8'h20, 2, 8'hFF, 1'b1, 1'b0, 1'b1, n);
        drain();
        issue(2'b10, 8'h18, 8'h28, 9, 8'h3C, 1'b0, 1'b0, 1'b1, n);
        drain();
        issue(2'b11, 8'h10, 8'h30, 13, 8'h05, 1'b0, 1'b0, 1'b1, n);
        drain();
        issue(2'b11, 8'h55, 8'h00, 2, 8'hFF, 1'b0, 1'b1, 1'b1, n);
        drain();

        // reset mid-multiply: outputs clear at once and no done follows
        issue(2'b10, 8'h1A, 8'h24, 9, 8'h00, 1'b0, 1'b0, 1'b0, n);
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_result", {int_out, frac_out}, 0);
        chk("midrst_flags", {ovf, dbz}, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(2'b00, 8'h08, 8'h08, 2, 8'h10, 1'b0, 1'b0, 1'b1, n);
        drain();

        // back-to-back with start held: accepted in each done cycle
        @(negedge clk);
        start = 1'b1; op = 2'b00; a = 8'h11; b = 8'h22;
        @(posedge clk);
        #1;
        n = cyc;
        push(8'h33, 1'b0, 1'b0, n + 2);
        a = 8'h40; b = 8'h05;
        repeat (3) @(posedge clk);
        #1;
        push(8'h45, 1'b0, 1'b0, n + 5);
        a = 8'h0F; b = 8'h01;
        repeat (3) @(posedge clk);
        #1;
        push(8'h10, 1'b0, 1'b0, n + 8);
        start = 1'b0;
        drain();
        repeat (5) @(posedge clk);
        #2;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
